// File: rtl/f2h_avmm_responder.sv
// Avalon-MM responder for the F2H tester master port: line memory, fixed-latency reads, counters.
// Define F2H_RESP_STALL_EN to enable the WAIT_CYCLES waitrequest stall FSM.
module f2h_avmm_responder #(
  parameter int DATA_W      = 512,
  parameter int ADDR_W      = 14,
  parameter int DEPTH_W     = 4,
  parameter int WAIT_CYCLES = 2,
  parameter int READ_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  avmm_write,
  input  logic                  avmm_read,
  input  logic [ADDR_W-1:0]     avmm_address,
  input  logic [DATA_W/8-1:0]   avmm_byteenable,
  input  logic [DATA_W-1:0]     avmm_writedata,
  output logic                  avmm_waitrequest,
  output logic [DATA_W-1:0]     avmm_readdata,
  output logic                  avmm_readdatavalid,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic                  err_sticky
);

  localparam int BYTES = DATA_W / 8;
  localparam int LINES = 2 ** DEPTH_W;
  localparam logic [DATA_W-1:0] FILL = {DATA_W/32{32'hDEAD_BEEF}};

  logic [DEPTH_W-1:0] line_idx;
  logic               req;
  logic               accept;
  logic               proto_err;
  logic               unused_addr_bits;

  // Only the line-select bits matter; everything else aliases.
  assign line_idx         = avmm_address[DEPTH_W+5:6];
  assign unused_addr_bits = ^avmm_address;
  assign req              = avmm_read | avmm_write;

  logic waitrequest_q;

`ifdef F2H_RESP_STALL_EN
  typedef enum logic [1:0] {IDLE, STALL, ACCEPT} state_e;

  state_e     state_q;
  logic [3:0] stall_cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      stall_cnt_q   <= '0;
      waitrequest_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          waitrequest_q <= 1'b1;
          if (req) begin
            stall_cnt_q <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_q       <= ACCEPT;
              waitrequest_q <= 1'b0;
            end else begin
              state_q <= STALL;
            end
          end
        end
        STALL: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (stall_cnt_q <= 4'd1) begin
            state_q       <= ACCEPT;
            stall_cnt_q   <= '0;
            waitrequest_q <= 1'b0;
          end else begin
            stall_cnt_q <= stall_cnt_q - 4'd1;
          end
        end
        ACCEPT: begin
          state_q       <= IDLE;
          waitrequest_q <= 1'b1;
        end
        default: begin
          state_q       <= IDLE;
          waitrequest_q <= 1'b1;
        end
      endcase
    end
  end

  assign accept    = (state_q == ACCEPT) & req;
  // A request withdrawn before the accept cycle has closed is a master-side violation.
  assign proto_err = ((state_q == STALL) | (state_q == ACCEPT)) & ~req;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) waitrequest_q <= 1'b1;
    else        waitrequest_q <= 1'b0;
  end

  assign accept    = req & ~waitrequest_q;
  assign proto_err = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [LINES];
  logic [LINES-1:0]  line_vld_q, line_vld_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [15:0]       rd_count_q, rd_count_d;
  logic              err_sticky_q, err_sticky_d;
  logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [DATA_W-1:0] pipe_data_q [READ_LAT];
  logic [DATA_W-1:0] pipe_data_d [READ_LAT];
  logic [DATA_W-1:0] base_line;
  logic [DATA_W-1:0] wr_line;
  logic              wr_commit;
  logic              rd_commit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_commit    = accept & avmm_write;
    rd_commit    = accept & ~avmm_write;
    base_line    = line_vld_q[line_idx] ? mem_q[line_idx] : FILL;
    wr_line      = base_line;
    line_vld_d   = line_vld_q;
    wr_count_d   = wr_count_q;
    rd_count_d   = rd_count_q;
    err_sticky_d = err_sticky_q | proto_err | (accept & avmm_write & avmm_read);

    for (int b = 0; b < BYTES; b++) begin
      if (avmm_byteenable[b]) wr_line[b*8 +: 8] = avmm_writedata[b*8 +: 8];
    end

    if (wr_commit) begin
      line_vld_d[line_idx] = 1'b1;
      if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
    end
    if (rd_commit && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;

    // Data stages only load behind a valid, so the last stage holds between pulses.
    pipe_vld_d[0]  = rd_commit;
    pipe_data_d[0] = rd_commit ? base_line : pipe_data_q[0];
    for (int k = 1; k < READ_LAT; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_data_d[k] = pipe_vld_q[k-1] ? pipe_data_q[k-1] : pipe_data_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_vld_q   <= '0;
      wr_count_q   <= '0;
      rd_count_q   <= '0;
      err_sticky_q <= 1'b0;
      pipe_vld_q   <= '0;
      for (int k = 0; k < READ_LAT; k++) pipe_data_q[k] <= '0;
    end else begin
      line_vld_q   <= line_vld_d;
      wr_count_q   <= wr_count_d;
      rd_count_q   <= rd_count_d;
      err_sticky_q <= err_sticky_d;
      pipe_vld_q   <= pipe_vld_d;
      for (int k = 0; k < READ_LAT; k++) pipe_data_q[k] <= pipe_data_d[k];
    end
  end

  // NOTE: line storage is deliberately not reset; line_vld_q masks stale contents with the fill pattern.
  always_ff @(posedge clk) begin
    if (wr_commit) mem_q[line_idx] <= wr_line;
  end

  assign avmm_waitrequest   = waitrequest_q;
  assign avmm_readdatavalid = pipe_vld_q[READ_LAT-1];
  assign avmm_readdata      = pipe_data_q[READ_LAT-1];
  assign wr_count           = wr_count_q;
  assign rd_count           = rd_count_q;
  assign err_sticky         = err_sticky_q;

endmodule

// File: tb/tb_f2h_avmm_responder.sv
// Directed bench for f2h_avmm_responder; expectations follow the F2H_RESP_STALL_EN build setting.
module tb_f2h_avmm_responder;

  localparam int DATA_W      = 512;
  localparam int ADDR_W      = 14;
  localparam int DEPTH_W     = 4;
  localparam int WAIT_CYCLES = 2;
  localparam int READ_LAT    = 3;
  localparam int BYTES       = DATA_W / 8;
  localparam logic [DATA_W-1:0] FILL = {DATA_W/32{32'hDEAD_BEEF}};

`ifdef F2H_RESP_STALL_EN
  localparam int   WAIT_LAT  = WAIT_CYCLES + 1;
  localparam logic WR_IDLE   = 1'b1;
`else
  localparam int   WAIT_LAT  = 0;
  localparam logic WR_IDLE   = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              avmm_write = 1'b0;
  logic              avmm_read = 1'b0;
  logic [ADDR_W-1:0] avmm_address = '0;
  logic [BYTES-1:0]  avmm_byteenable = '0;
  logic [DATA_W-1:0] avmm_writedata = '0;
  logic              avmm_waitrequest;
  logic [DATA_W-1:0] avmm_readdata;
  logic              avmm_readdatavalid;
  logic [15:0]       wr_count;
  logic [15:0]       rd_count;
  logic              err_sticky;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] line1_exp;
  logic [DATA_W-1:0] line9_exp;

  always #5 clk = ~clk;

  f2h_avmm_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W),
    .WAIT_CYCLES(WAIT_CYCLES), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .avmm_write(avmm_write), .avmm_read(avmm_read),
    .avmm_address(avmm_address), .avmm_byteenable(avmm_byteenable),
    .avmm_writedata(avmm_writedata), .avmm_waitrequest(avmm_waitrequest),
    .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid),
    .wr_count(wr_count), .rd_count(rd_count), .err_sticky(err_sticky)
  );

  // Drive a command from a negedge and hold it until accepted; lat counts stalled negedges.
  task automatic issue(input logic wr, input logic rd, input logic [ADDR_W-1:0] addr,
                       input logic [BYTES-1:0] be, input logic [DATA_W-1:0] wd,
                       output int lat);
    avmm_write      = wr;
    avmm_read       = rd;
    avmm_address    = addr;
    avmm_byteenable = be;
    avmm_writedata  = wd;
    lat = 0;
    while (avmm_waitrequest && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    @(posedge clk);
    #1;
    avmm_write = 1'b0;
    avmm_read  = 1'b0;
  endtask

  task automatic wait_rdv(output int lat, output logic [DATA_W-1:0] data);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!avmm_readdatavalid && lat < 20);
    data = avmm_readdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (avmm_waitrequest !== 1'b1) begin
      errors++; $display("FAIL reset_waitrequest: got %b want 1", avmm_waitrequest);
    end
    checks++;
    if (avmm_readdata !== '0) begin
      errors++; $display("FAIL reset_readdata: got %h want 0", avmm_readdata);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (avmm_waitrequest !== WR_IDLE) begin
      errors++; $display("FAIL idle_waitrequest: got %b want %b", avmm_waitrequest, WR_IDLE);
    end
    checks++;
    if ({avmm_readdatavalid, err_sticky, wr_count, rd_count} !== 34'd0) begin
      errors++; $display("FAIL idle_status: rdv=%b err=%b wr=%0d rd=%0d want all 0",
                         avmm_readdatavalid, err_sticky, wr_count, rd_count);
    end
  endtask

  task automatic test_write();
    int lat;
    @(negedge clk);
    line1_exp = {{(DATA_W-32){1'b0}}, 32'hDEAF_DEAD};
    issue(1'b1, 1'b0, 14'h0C40, '1, line1_exp, lat);
    checks++;
    if (lat !== WAIT_LAT) begin
      errors++; $display("FAIL write_wait_latency: got %0d want %0d", lat, WAIT_LAT);
    end
    @(negedge clk);
    checks++;
    if (avmm_waitrequest !== WR_IDLE) begin
      errors++; $display("FAIL write_accept_width: waitrequest got %b want %b", avmm_waitrequest, WR_IDLE);
    end
    checks++;
    if (wr_count !== 16'd1 || rd_count !== 16'd0) begin
      errors++; $display("FAIL write_counts: wr=%0d rd=%0d want 1 0", wr_count, rd_count);
    end
  endtask

  task automatic test_read_alias();
    int lat, rlat;
    logic [DATA_W-1:0] data;
    @(negedge clk);
    issue(1'b0, 1'b1, 14'h0040, '0, '0, lat);
    checks++;
    if (lat !== WAIT_LAT) begin
      errors++; $display("FAIL read_wait_latency: got %0d want %0d", lat, WAIT_LAT);
    end
    wait_rdv(rlat, data);
    checks++;
    if (rlat !== READ_LAT) begin
      errors++; $display("FAIL read_latency: got %0d want %0d", rlat, READ_LAT);
    end
    checks++;
    if (data !== line1_exp) begin
      errors++; $display("FAIL read_alias_data: got %h want %h", data, line1_exp);
    end
    @(negedge clk);
    checks++;
    if (avmm_readdatavalid !== 1'b0 || avmm_readdata !== line1_exp) begin
      errors++; $display("FAIL read_pulse_hold: rdv=%b data=%h want 0 and held %h",
                         avmm_readdatavalid, avmm_readdata, line1_exp);
    end
    checks++;
    if (rd_count !== 16'd1) begin
      errors++; $display("FAIL read_count: got %0d want 1", rd_count);
    end
  endtask

  task automatic test_unwritten_partial();
    int lat, rlat;
    logic [DATA_W-1:0] data;
    @(negedge clk);
    issue(1'b0, 1'b1, 14'h0666, '0, '0, lat);
    wait_rdv(rlat, data);
    checks++;
    if (rlat !== READ_LAT || data !== FILL) begin
      errors++; $display("FAIL unwritten_fill: lat=%0d got %h want %h", rlat, data, FILL);
    end
    @(negedge clk);
    issue(1'b1, 1'b0, 14'h0666, 64'h0F, {{15{32'h1234_5678}}, 32'hACAC_0505}, lat);
    line9_exp        = FILL;
    line9_exp[31:0]  = 32'hACAC_0505;
    @(negedge clk);
    issue(1'b0, 1'b1, 14'h0666, '0, '0, lat);
    wait_rdv(rlat, data);
    checks++;
    if (rlat !== READ_LAT || data !== line9_exp) begin
      errors++; $display("FAIL partial_merge: lat=%0d got %h want %h", rlat, data, line9_exp);
    end
    checks++;
    if (wr_count !== 16'd2 || rd_count !== 16'd3) begin
      errors++; $display("FAIL partial_counts: wr=%0d rd=%0d want 2 3", wr_count, rd_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [4];
    logic [DATA_W-1:0] exps  [4];
    addrs[0] = 14'h0040; exps[0] = line1_exp;
    addrs[1] = 14'h0666; exps[1] = line9_exp;
    addrs[2] = 14'h0080; exps[2] = FILL;
    addrs[3] = 14'h3C7F; exps[3] = line1_exp;
    @(negedge clk);
`ifdef F2H_RESP_STALL_EN
    for (int i = 0; i < 4; i++) begin
      int lat, rlat;
      logic [DATA_W-1:0] data;
      issue(1'b0, 1'b1, addrs[i], '0, '0, lat);
      wait_rdv(rlat, data);
      checks++;
      if (rlat !== READ_LAT || data !== exps[i]) begin
        errors++; $display("FAIL seq_read%0d: lat=%0d got %h want %h", i, rlat, data, exps[i]);
      end
      @(negedge clk);
    end
`else
    for (int i = 0; i < 8; i++) begin
      logic exp_v;
      exp_v = (i >= READ_LAT) && (i < READ_LAT + 4);
      checks++;
      if (avmm_readdatavalid !== exp_v) begin
        errors++; $display("FAIL b2b_valid%0d: got %b want %b", i, avmm_readdatavalid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (avmm_readdata !== exps[i-READ_LAT]) begin
          errors++; $display("FAIL b2b_data%0d: got %h want %h", i - READ_LAT, avmm_readdata, exps[i-READ_LAT]);
        end
      end
      if (i < 4) begin
        avmm_read    = 1'b1;
        avmm_address = addrs[i];
        checks++;
        if (avmm_waitrequest !== 1'b0) begin
          errors++; $display("FAIL b2b_accept%0d: waitrequest got %b want 0", i, avmm_waitrequest);
        end
      end else begin
        avmm_read = 1'b0;
      end
      @(negedge clk);
    end
`endif
    checks++;
    if (rd_count !== 16'd7) begin
      errors++; $display("FAIL b2b_count: got %0d want 7", rd_count);
    end
  endtask

  task automatic test_errors();
    int lat, rlat;
    int seen;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
    exp = {{(DATA_W-32){1'b0}}, 32'h1111_2222};
    @(negedge clk);
    issue(1'b1, 1'b1, 14'h0080, '1, exp, lat);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (avmm_readdatavalid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rw_no_return: got %0d pulses want 0", seen);
    end
    checks++;
    if (err_sticky !== 1'b1 || wr_count !== 16'd3 || rd_count !== 16'd7) begin
      errors++; $display("FAIL rw_status: err=%b wr=%0d rd=%0d want 1 3 7", err_sticky, wr_count, rd_count);
    end
`ifdef F2H_RESP_STALL_EN
    avmm_read    = 1'b1;
    avmm_address = 14'h0040;
    @(negedge clk);
    avmm_read = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (avmm_readdatavalid) seen++;
    end
    checks++;
    if (seen !== 0 || err_sticky !== 1'b1 || rd_count !== 16'd7 || avmm_waitrequest !== 1'b1) begin
      errors++; $display("FAIL drop_stall: pulses=%0d err=%b rd=%0d wreq=%b want 0 1 7 1",
                         seen, err_sticky, rd_count, avmm_waitrequest);
    end
`endif
    issue(1'b0, 1'b1, 14'h0080, '0, '0, lat);
    wait_rdv(rlat, data);
    checks++;
    if (rlat !== READ_LAT || data !== exp) begin
      errors++; $display("FAIL rw_committed: lat=%0d got %h want %h", rlat, data, exp);
    end
  endtask

  task automatic test_reset_inflight();
    int lat, rlat, seen;
    logic [DATA_W-1:0] data;
    @(negedge clk);
    issue(1'b0, 1'b1, 14'h0040, '0, '0, lat);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (avmm_waitrequest !== 1'b1 || avmm_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL async_reset: wreq=%b rdv=%b want 1 0", avmm_waitrequest, avmm_readdatavalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (avmm_readdatavalid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_inflight: got %0d pulses want 0", seen);
    end
    checks++;
    if (err_sticky !== 1'b0 || wr_count !== 16'd0 || rd_count !== 16'd0 || avmm_readdata !== '0) begin
      errors++; $display("FAIL post_reset_state: err=%b wr=%0d rd=%0d data=%h want 0",
                         err_sticky, wr_count, rd_count, avmm_readdata);
    end
    issue(1'b0, 1'b1, 14'h0040, '0, '0, lat);
    wait_rdv(rlat, data);
    checks++;
    if (rlat !== READ_LAT || data !== FILL) begin
      errors++; $display("FAIL valid_cleared: lat=%0d got %h want %h", rlat, data, FILL);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_alias();
    test_unwritten_partial();
    test_back_to_back();
    test_errors();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
